// File: rtl/fp_add_align_stage.sv
// rtl/fp_add_align_stage.sv - FP add/sub/cmp operand classify, sort and align stage with skid buffer
module fp_add_align_stage #(
  parameter int NUM_LANES        = 16,
  parameter int EXP_WIDTH        = 8,
  parameter int SIG_WIDTH        = 23,
  parameter int MAX_ALIGN_SHIFT  = 27,
  parameter int THREAD_IDX_WIDTH = 2
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  rollback_en,
  input  logic [THREAD_IDX_WIDTH-1:0]                           rollback_thread_idx,
  input  logic                                                  in_valid,
  output logic                                                  in_ready,
  input  logic [1:0]                                            in_op,
  input  logic [THREAD_IDX_WIDTH-1:0]                           in_thread_idx,
  input  logic [NUM_LANES-1:0]                                  in_mask,
  input  logic [NUM_LANES*(1+EXP_WIDTH+SIG_WIDTH)-1:0]          in_operand1,
  input  logic [NUM_LANES*(1+EXP_WIDTH+SIG_WIDTH)-1:0]          in_operand2,
  output logic                                                  out_valid,
  input  logic                                                  out_ready,
  output logic [1:0]                                            out_op,
  output logic [THREAD_IDX_WIDTH-1:0]                           out_thread_idx,
  output logic [NUM_LANES-1:0]                                  out_mask,
  output logic [NUM_LANES*(SIG_WIDTH+1)-1:0]                    out_significand_le,
  output logic [NUM_LANES*(SIG_WIDTH+1)-1:0]                    out_significand_se,
  output logic [NUM_LANES*$clog2(MAX_ALIGN_SHIFT+1)-1:0]        out_align_shift,
  output logic [NUM_LANES*EXP_WIDTH-1:0]                        out_exponent,
  output logic [NUM_LANES-1:0]                                  out_logical_subtract,
  output logic [NUM_LANES-1:0]                                  out_result_sign,
  output logic [NUM_LANES-1:0]                                  out_result_nan,
  output logic [NUM_LANES-1:0]                                  out_result_inf,
  output logic [NUM_LANES-1:0]                                  out_equal
);

  localparam int W       = 1 + EXP_WIDTH + SIG_WIDTH;
  localparam int SHW     = $clog2(MAX_ALIGN_SHIFT + 1);
  localparam int FW      = SIG_WIDTH + 1;
  localparam int TW      = THREAD_IDX_WIDTH;
  localparam int LW      = 2 * FW + SHW + EXP_WIDTH + 5;
  localparam int LANES_W = NUM_LANES * LW;
  localparam int PW      = 2 + TW + NUM_LANES + LANES_W;

  // Per-lane record layout, LSB first
  localparam int O_EQ   = 0;
  localparam int O_INF  = 1;
  localparam int O_NAN  = 2;
  localparam int O_SIGN = 3;
  localparam int O_LS   = 4;
  localparam int O_EXP  = 5;
  localparam int O_SH   = O_EXP + EXP_WIDTH;
  localparam int O_SE   = O_SH + SHW;
  localparam int O_LE   = O_SE + FW;

  // Beat payload layout above the lane records
  localparam int O_MASK = LANES_W;
  localparam int O_THR  = O_MASK + NUM_LANES;
  localparam int O_OP   = O_THR + TW;

  logic          is_sub;
  logic          is_cmp;
  logic [LANES_W-1:0] in_lanes;
  logic [PW-1:0] in_payload;

  assign is_sub = (in_op != 2'd0);
  assign is_cmp = (in_op == 2'd2);

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      logic [W-1:0]         a;
      logic [W-1:0]         b;
      logic                 s1;
      logic                 s2;
      logic [EXP_WIDTH-1:0] e1;
      logic [EXP_WIDTH-1:0] e2;
      logic [FW-1:0]        f1;
      logic [FW-1:0]        f2;
      logic                 nan1;
      logic                 nan2;
      logic                 inf1;
      logic                 inf2;
      logic                 op1_larger;
      logic [EXP_WIDTH-1:0] diff;
      logic [SHW-1:0]       sh;
      logic                 ls;
      logic                 sgn;
      logic                 rnan;
      logic                 rinf;
      logic                 eq;
      logic [LW-1:0]        rec;

      assign a    = in_operand1[g*W +: W];
      assign b    = in_operand2[g*W +: W];
      assign s1   = a[W-1];
      assign s2   = b[W-1];
      assign e1   = a[SIG_WIDTH +: EXP_WIDTH];
      assign e2   = b[SIG_WIDTH +: EXP_WIDTH];
      assign f1   = {(e1 != '0), a[SIG_WIDTH-1:0]};
      assign f2   = {(e2 != '0), b[SIG_WIDTH-1:0]};
      assign nan1 = (&e1) && (a[SIG_WIDTH-1:0] != '0);
      assign nan2 = (&e2) && (b[SIG_WIDTH-1:0] != '0);
      assign inf1 = (&e1) && (a[SIG_WIDTH-1:0] == '0);
      assign inf2 = (&e2) && (b[SIG_WIDTH-1:0] == '0);

      // Ties keep operand A in the le lane
      assign op1_larger = (e1 > e2) || ((e1 == e2) && (f1 >= f2));
      assign diff = op1_larger ? (e1 - e2) : (e2 - e1);
      assign sh   = (32'(diff) > MAX_ALIGN_SHIFT) ? SHW'(MAX_ALIGN_SHIFT) : SHW'(diff);
      assign ls   = s1 ^ s2 ^ is_sub;
      assign sgn  = op1_larger ? s1 : (s2 ^ is_sub);
      assign rnan = nan1 || nan2 || (!is_cmp && inf1 && inf2 && ls);
      assign rinf = !rnan && (inf1 || inf2);
      assign eq   = (inf1 && inf2 && (s1 == s2)) || (!inf1 && !inf2 && (a == b));

      // Pack the lane result, zeroing inactive lanes
      always_comb begin
        rec = '0;
        if (in_mask[g]) begin
          rec = {op1_larger ? f1 : f2,
                 op1_larger ? f2 : f1,
                 sh,
                 op1_larger ? e1 : e2,
                 ls, sgn, rnan, rinf, eq};
        end
      end

      assign in_lanes[g*LW +: LW] = rec;
    end
  endgenerate

  assign in_payload = {in_op, in_thread_idx, in_mask, in_lanes};

  logic          main_valid;
  logic          skid_valid;
  logic [PW-1:0] main_data;
  logic [PW-1:0] skid_data;
  logic          in_squash;
  logic          main_squash;
  logic          skid_squash;
  logic          main_live;
  logic          skid_live;
  logic          main_free;
  logic          accept;

  assign in_squash   = rollback_en && (in_thread_idx == rollback_thread_idx);
  assign main_squash = rollback_en && main_valid && (main_data[O_THR +: TW] == rollback_thread_idx);
  assign skid_squash = rollback_en && skid_valid && (skid_data[O_THR +: TW] == rollback_thread_idx);
  assign main_live   = main_valid && !main_squash;
  assign skid_live   = skid_valid && !skid_squash;
  assign main_free   = !main_live || out_ready;
  assign in_ready    = !skid_valid;
  assign accept      = in_valid && in_ready && !in_squash;
  assign out_valid   = main_live;

  // Main/skid pair: skid refills main first, new beats fill whichever slot frees up
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (main_free) begin
      if (skid_live) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_data  <= in_payload;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_payload;
    end else begin
      skid_valid <= skid_live;
    end
  end

  assign out_op         = main_data[O_OP +: 2];
  assign out_thread_idx = main_data[O_THR +: TW];
  assign out_mask       = main_data[O_MASK +: NUM_LANES];

  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_out
      assign out_significand_le[g*FW +: FW]             = main_data[g*LW + O_LE +: FW];
      assign out_significand_se[g*FW +: FW]             = main_data[g*LW + O_SE +: FW];
      assign out_align_shift[g*SHW +: SHW]              = main_data[g*LW + O_SH +: SHW];
      assign out_exponent[g*EXP_WIDTH +: EXP_WIDTH]     = main_data[g*LW + O_EXP +: EXP_WIDTH];
      assign out_logical_subtract[g]                    = main_data[g*LW + O_LS];
      assign out_result_sign[g]                         = main_data[g*LW + O_SIGN];
      assign out_result_nan[g]                          = main_data[g*LW + O_NAN];
      assign out_result_inf[g]                          = main_data[g*LW + O_INF];
      assign out_equal[g]                               = main_data[g*LW + O_EQ];
    end
  endgenerate

endmodule

// File: tb/tb_fp_add_align_stage.sv
// tb/tb_fp_add_align_stage.sv - directed self-checking bench for fp_add_align_stage
module tb_fp_add_align_stage;

  localparam int NL  = 16;
  localparam int W   = 32;
  localparam int FW  = 24;
  localparam int SHW = 5;
  localparam int EW  = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            rollback_en;
  logic [1:0]      rollback_thread_idx;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic [1:0]      in_thread_idx;
  logic [NL-1:0]   in_mask;
  logic [NL*W-1:0] in_operand1;
  logic [NL*W-1:0] in_operand2;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_op;
  logic [1:0]      out_thread_idx;
  logic [NL-1:0]   out_mask;
  logic [NL*FW-1:0]  out_significand_le;
  logic [NL*FW-1:0]  out_significand_se;
  logic [NL*SHW-1:0] out_align_shift;
  logic [NL*EW-1:0]  out_exponent;
  logic [NL-1:0]   out_logical_subtract;
  logic [NL-1:0]   out_result_sign;
  logic [NL-1:0]   out_result_nan;
  logic [NL-1:0]   out_result_inf;
  logic [NL-1:0]   out_equal;

  int checks = 0;
  int errors = 0;
  int hs_q[$];

  fp_add_align_stage dut (
    .clk                  (clk),
    .reset                (reset),
    .rollback_en          (rollback_en),
    .rollback_thread_idx  (rollback_thread_idx),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_op                (in_op),
    .in_thread_idx        (in_thread_idx),
    .in_mask              (in_mask),
    .in_operand1          (in_operand1),
    .in_operand2          (in_operand2),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_op               (out_op),
    .out_thread_idx       (out_thread_idx),
    .out_mask             (out_mask),
    .out_significand_le   (out_significand_le),
    .out_significand_se   (out_significand_se),
    .out_align_shift      (out_align_shift),
    .out_exponent         (out_exponent),
    .out_logical_subtract (out_logical_subtract),
    .out_result_sign      (out_result_sign),
    .out_result_nan       (out_result_nan),
    .out_result_inf       (out_result_inf),
    .out_equal            (out_equal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset && out_valid && out_ready) hs_q.push_back(int'(out_thread_idx));
  end

  function automatic logic [65:0] lane_rec(input int l);
    return {out_significand_le[l*FW +: FW], out_significand_se[l*FW +: FW],
            out_align_shift[l*SHW +: SHW], out_exponent[l*EW +: EW],
            out_logical_subtract[l], out_result_sign[l], out_result_nan[l],
            out_result_inf[l], out_equal[l]};
  endfunction

  function automatic logic [65:0] mk(input logic [23:0] le, input logic [23:0] se,
                                     input logic [4:0] sh, input logic [7:0] ex,
                                     input logic ls, input logic sg, input logic nan,
                                     input logic inf, input logic eq);
    return {le, se, sh, ex, ls, sg, nan, inf, eq};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [1:0] op, input logic [1:0] thr, input logic [NL-1:0] m,
                          input logic [31:0] a, input logic [31:0] b);
    in_valid      = 1'b1;
    in_op         = op;
    in_thread_idx = thr;
    in_mask       = m;
    in_operand1   = {NL{a}};
    in_operand2   = {NL{b}};
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if ({out_significand_le, out_exponent, out_mask, out_thread_idx, out_op} !== '0) begin
      errors++; $display("FAIL reset_data got le=%h exp=%h mask=%h want all zero", out_significand_le, out_exponent, out_mask);
    end
    #2 reset = 1'b1;
    step();
  endtask

  task automatic test_add_sub();
    logic [1:0]  ops [6];
    logic [31:0] va  [6];
    logic [31:0] vb  [6];
    logic [65:0] ve  [6];
    ops = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd0, 2'd2};
    va  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h00000000};
    vb  = '{32'h40000000, 32'h40000000, 32'h3F800000, 32'h40000000, 32'h3FC00000, 32'h80000000};
    ve[0] = mk(24'h800000, 24'h800000, 5'd1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ve[1] = mk(24'h800000, 24'h800000, 5'd1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ve[2] = mk(24'h800000, 24'h800000, 5'd0, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    ve[3] = mk(24'h800000, 24'h800000, 5'd1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ve[4] = mk(24'hC00000, 24'h800000, 5'd0, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ve[5] = mk(24'h000000, 24'h000000, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_beat(ops[i], 2'd0, 16'h0001, va[i], vb[i]);
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL addsub_valid[%0d] got %b want 1", i, out_valid); end
      checks++;
      if (lane_rec(0) !== ve[i]) begin errors++; $display("FAIL addsub_lane0[%0d] got %h want %h", i, lane_rec(0), ve[i]); end
      checks++;
      if (out_op !== ops[i]) begin errors++; $display("FAIL addsub_op[%0d] got %0d want %0d", i, out_op, ops[i]); end
    end
    step();
  endtask

  task automatic test_specials();
    logic [1:0]  ops [4];
    logic [31:0] va  [4];
    logic [31:0] vb  [4];
    logic [65:0] ve  [4];
    ops = '{2'd0, 2'd2, 2'd0, 2'd0};
    va  = '{32'h7F800000, 32'h7FC00000, 32'h7F800000, 32'h7F000000};
    vb  = '{32'hFF800000, 32'h3F800000, 32'h3F800000, 32'h00800000};
    ve[0] = mk(24'h800000, 24'h800000, 5'd0,  8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    ve[1] = mk(24'hC00000, 24'h800000, 5'd27, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    ve[2] = mk(24'h800000, 24'h800000, 5'd27, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    ve[3] = mk(24'h800000, 24'h800000, 5'd27, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_beat(ops[i], 2'd1, 16'h0001, va[i], vb[i]);
      step();
      in_valid = 1'b0;
      checks++;
      if (lane_rec(0) !== ve[i]) begin errors++; $display("FAIL special_lane0[%0d] got %h want %h", i, lane_rec(0), ve[i]); end
    end
    step();
  endtask

  task automatic test_mask();
    out_ready = 1'b1;
    set_beat(2'd0, 2'd3, 16'hFFF7, 32'h3F800000, 32'h40000000);
    step();
    in_valid = 1'b0;
    checks++;
    if (lane_rec(3) !== 66'd0) begin errors++; $display("FAIL mask_lane3 got %h want 0", lane_rec(3)); end
    checks++;
    if (lane_rec(0) !== mk(24'h800000, 24'h800000, 5'd1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
      errors++; $display("FAIL mask_lane0 got %h want active record", lane_rec(0));
    end
    checks++;
    if ({out_mask, out_thread_idx} !== {16'hFFF7, 2'd3}) begin
      errors++; $display("FAIL mask_meta got mask=%h thr=%0d want fff7/3", out_mask, out_thread_idx);
    end
    step();
  endtask

  task automatic test_back_to_back();
    hs_q.delete();
    out_ready = 1'b0;
    set_beat(2'd0, 2'd0, 16'h0001, 32'h3F800000, 32'h00000000);
    step();
    checks++;
    if ({out_valid, out_thread_idx, in_ready} !== {1'b1, 2'd0, 1'b1}) begin
      errors++; $display("FAIL b2b_t0 got v=%b thr=%0d rdy=%b want 1/0/1", out_valid, out_thread_idx, in_ready);
    end
    set_beat(2'd0, 2'd1, 16'h0001, 32'h40000000, 32'h00000000);
    step();
    checks++;
    if ({in_ready, out_thread_idx} !== {1'b0, 2'd0}) begin
      errors++; $display("FAIL b2b_t1 got rdy=%b thr=%0d want 0/0", in_ready, out_thread_idx);
    end
    set_beat(2'd0, 2'd2, 16'h0001, 32'h40800000, 32'h00000000);
    step();
    step();
    checks++;
    if ({in_ready, out_valid, out_thread_idx, out_exponent[7:0]} !== {1'b0, 1'b1, 2'd0, 8'h7F}) begin
      errors++; $display("FAIL b2b_hold got rdy=%b v=%b thr=%0d exp=%h want 0/1/0/7f", in_ready, out_valid, out_thread_idx, out_exponent[7:0]);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if ({in_ready, out_thread_idx, out_exponent[7:0]} !== {1'b1, 2'd1, 8'h80}) begin
      errors++; $display("FAIL b2b_drain1 got rdy=%b thr=%0d exp=%h want 1/1/80", in_ready, out_thread_idx, out_exponent[7:0]);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_thread_idx, out_exponent[7:0]} !== {1'b1, 2'd2, 8'h81}) begin
      errors++; $display("FAIL b2b_drain2 got v=%b thr=%0d exp=%h want 1/2/81", out_valid, out_thread_idx, out_exponent[7:0]);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b want 0", out_valid); end
    checks++;
    if (hs_q.size() != 3 || hs_q[0] != 0 || hs_q[1] != 1 || hs_q[2] != 2) begin
      errors++; $display("FAIL b2b_order got %p want '{0,1,2}", hs_q);
    end
  endtask

  task automatic test_rollback();
    hs_q.delete();
    out_ready = 1'b0;
    set_beat(2'd0, 2'd1, 16'h0001, 32'h3F800000, 32'h00000000);
    step();
    set_beat(2'd0, 2'd2, 16'h0001, 32'h40000000, 32'h00000000);
    step();
    set_beat(2'd0, 2'd1, 16'h0001, 32'h40800000, 32'h00000000);
    rollback_en = 1'b1;
    rollback_thread_idx = 2'd1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rb_squash_present got %b want 0", out_valid); end
    step();
    rollback_en = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_thread_idx, out_exponent[7:0], in_ready} !== {1'b1, 2'd2, 8'h80, 1'b1}) begin
      errors++; $display("FAIL rb_promote got v=%b thr=%0d exp=%h rdy=%b want 1/2/80/1", out_valid, out_thread_idx, out_exponent[7:0], in_ready);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (hs_q.size() != 1 || hs_q[0] != 2 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rb_handshakes got %p v=%b want '{2} v=0", hs_q, out_valid);
    end
    set_beat(2'd0, 2'd3, 16'h0001, 32'h3F800000, 32'h00000000);
    rollback_en = 1'b1;
    rollback_thread_idx = 2'd3;
    step();
    rollback_en = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rb_incoming got %b want 0", out_valid); end
    set_beat(2'd0, 2'd1, 16'h0001, 32'h3F800000, 32'h00000000);
    step();
    in_valid = 1'b0;
    rollback_en = 1'b1;
    rollback_thread_idx = 2'd1;
    step();
    rollback_en = 1'b0;
    checks++;
    if (hs_q.size() != 1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rb_priority got %p v=%b want '{2} v=0", hs_q, out_valid);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    set_beat(2'd1, 2'd1, 16'hFFFF, 32'h3F800000, 32'h40000000);
    step();
    set_beat(2'd1, 2'd2, 16'hFFFF, 32'h40000000, 32'h3F800000);
    step();
    in_valid = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== {1'b0, 1'b1}) begin
      errors++; $display("FAIL areset_pre got rdy=%b v=%b want 0/1", in_ready, out_valid);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready} !== {1'b0, 1'b1}) begin
      errors++; $display("FAIL areset_flags got v=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    checks++;
    if ({out_significand_le, out_significand_se, out_exponent, out_mask, out_op, out_thread_idx,
         out_logical_subtract, out_result_sign} !== '0) begin
      errors++; $display("FAIL areset_data got le=%h exp=%h mask=%h op=%0d want all zero", out_significand_le, out_exponent, out_mask, out_op);
    end
    #2 reset = 1'b1;
    step();
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_no_survivor got %b want 0", out_valid); end
  endtask

  initial begin
    reset = 1'b0;
    rollback_en = 1'b0;
    rollback_thread_idx = '0;
    in_valid = 1'b0;
    in_op = '0;
    in_thread_idx = '0;
    in_mask = '0;
    in_operand1 = '0;
    in_operand2 = '0;
    out_ready = 1'b0;
    test_reset();
    test_add_sub();
    test_specials();
    test_mask();
    test_back_to_back();
    test_rollback();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_add_align_stage.md
Name: fp_add_align_stage

Overview:
- Parametrised, flow-controlled front end for the floating point add/subtract/compare pipe.
- Per lane, it unpacks both operands, classifies NaN/Inf and detects equality.
- It sorts the operands into larger-magnitude (le) and smaller-magnitude (se) lanes and computes a saturated alignment shift.
- Sits between operand fetch and the alignment shifter. Unlike the fixed-width stage before it, it adds a valid/ready handshake with a two-entry skid buffer, per-thread rollback squash, and configurable lane count and float format.

Parameters:
- NUM_LANES, 16, number of vector lanes.
- EXP_WIDTH, 8, exponent field width.
- SIG_WIDTH, 23, stored significand width (hidden bit excluded).
- MAX_ALIGN_SHIFT, 27, saturation value of the alignment shift; must be at least SIG_WIDTH+4.
- THREAD_IDX_WIDTH, 2, thread index width.
- Derived: W = 1+EXP_WIDTH+SIG_WIDTH; SHW = clog2(MAX_ALIGN_SHIFT+1).

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous, active-low reset.
- rollback_en, in, 1, squash request from writeback.
- rollback_thread_idx, in, THREAD_IDX_WIDTH, thread being squashed.
- in_valid, in, 1, input beat valid.
- in_ready, out, 1, stage can accept a beat.
- in_op, in, 2, operation: 0=ADD, 1=SUB, 2=CMP, 3=reserved (treated as SUB).
- in_thread_idx, in, THREAD_IDX_WIDTH, issuing thread.
- in_mask, in, NUM_LANES, active lanes.
- in_operand1, in, NUM_LANES*W, operand A per lane.
- in_operand2, in, NUM_LANES*W, operand B per lane.
- out_valid, out, 1, output beat valid.
- out_ready, in, 1, downstream accepts the beat.
- out_op, out, 2, registered in_op.
- out_thread_idx, out, THREAD_IDX_WIDTH, registered thread.
- out_mask, out, NUM_LANES, registered mask.
- out_significand_le, out, NUM_LANES*(SIG_WIDTH+1), larger-magnitude significand including hidden bit.
- out_significand_se, out, NUM_LANES*(SIG_WIDTH+1), smaller-magnitude significand.
- out_align_shift, out, NUM_LANES*SHW, right shift to apply to se.
- out_exponent, out, NUM_LANES*EXP_WIDTH, exponent of the le operand.
- out_logical_subtract, out, NUM_LANES, effective subtraction.
- out_result_sign, out, NUM_LANES, sign of the result.
- out_result_nan, out, NUM_LANES, result is NaN.
- out_result_inf, out, NUM_LANES, result is infinite.
- out_equal, out, NUM_LANES, operands compare equal.

Behaviour:
- Reset (reset=0, asynchronous):
  - Both buffer entries are invalid, so out_valid=0 and in_ready=1.
  - All data outputs are 0.
  - Reset taking effect mid-transfer discards all in-flight beats; no partial beat survives.
- Buffer structure: a main output register plus one skid register.
  - in_ready is a registered signal, equal to "skid entry empty".
  - A beat is accepted when in_valid && in_ready.
- Latency and ordering:
  - An accepted beat appears on the out_* ports in the next cycle, provided the main register is empty or is draining that cycle.
  - Otherwise it goes to the skid register and moves to main on the first cycle main drains.
  - Order is strictly FIFO.
- A beat leaves the stage when out_valid && out_ready. out_* are held stable while out_valid=1 and out_ready=0.
- Rollback, when rollback_en=1 in a cycle:
  - Any beat whose thread equals rollback_thread_idx is squashed: the incoming beat, the main register and the skid register.
  - A squashed beat is neither accepted nor presented.
  - If main is squashed and skid survives, skid moves to main in the same cycle.
  - A squash of main takes priority over out_ready; no handshake completes for a squashed beat.
- Per-lane arithmetic, computed combinationally before the register:
  - Hidden bit = (exponent != 0).
  - NaN = (exp all ones) && (sig != 0). Inf = (exp all ones) && (sig == 0).
  - op1_larger = e1 > e2, or (e1 == e2 and full_sig1 >= full_sig2). On a tie, operand A stays in le.
  - logical_subtract = s1 ^ s2 ^ (in_op != ADD).
  - result_sign = s1 if op1_larger, else s2 ^ (in_op != ADD).
  - align_shift = min(|e1-e2|, MAX_ALIGN_SHIFT).
  - out_exponent = exponent of the le operand.
  - For CMP: result_nan = nan1 || nan2.
  - For ADD/SUB: result_nan = nan1 || nan2 || (inf1 && inf2 && logical_subtract).
  - result_inf = !result_nan && (inf1 || inf2).
  - equal = (inf1 && inf2 && s1 == s2) || (!inf1 && !inf2 && op1 == op2 bitwise).
  - +0 vs -0 is NOT equal; downstream resolves this.
- Lanes with in_mask bit 0 register zeros on every per-lane output field. out_mask still carries the mask.

Test Plan:
- ADD, lane0 A=0x3F800000, B=0x40000000, mask=1, out_ready=1 -> next cycle: le=0x800000, se=0x800000, shift=1, exp=0x80, logical_subtract=0, sign=0, nan=0, inf=0.
- SUB, A=0x3F800000, B=0x40000000 -> le from B, sign=1, logical_subtract=1. Same op with A=B=0x3F800000 -> equal=1, sign=0.
- Specials: ADD 0x7F800000 + 0xFF800000 -> nan=1, inf=0. CMP 0x7FC00000 vs 0x3F800000 -> nan=1. ADD 0x7F800000 + 0x3F800000 -> inf=1. A=0x7F000000, B=0x00800000 -> shift=27 (saturated).
- Backpressure: three back-to-back beats T0,T1,T2 with out_ready=0 -> T0 and T1 accepted, in_ready=0 from the cycle after T1. out_ready then held at 1 -> output order T0, T1, T2, with no beat lost or duplicated.
- Rollback: main=thread1, skid=thread2, rollback_en=1 with thread 1, out_ready=0 -> next cycle out_thread_idx=2 and out_valid=1; the thread-1 beat never handshakes. An incoming thread-1 beat in the same cycle is dropped.
- Reset pulled low with both entries full -> out_valid=0, in_ready=1 and all outputs 0 immediately, without waiting for a clock edge. Mask bit 0 on lane3 -> lane3 data fields are 0.
